// File: rtl/div_seq_if.sv
// rtl/div_seq_if.sv - issue/writeback interface between ex and the divide sequencer
//
// master : ex side; drives the divide request and observes hold/writeback
// slave  : div_seq side
//   start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i : request (master -> slave)
//   busy_o, ready_o, result_o, reg_we_o, reg_waddr_o            : hold + writeback (slave -> master)
interface div_seq_if #(
  parameter int DIV_W = 32
);
  logic             start_i;
  logic [2:0]       op_i;
  logic [DIV_W-1:0] dividend_i;
  logic [DIV_W-1:0] divisor_i;
  logic [4:0]       reg_waddr_i;
  logic             abort_i;
  logic             busy_o;
  logic             ready_o;
  logic [DIV_W-1:0] result_o;
  logic             reg_we_o;
  logic [4:0]       reg_waddr_o;

  modport master (
    output start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i,
    input  busy_o, ready_o, result_o, reg_we_o, reg_waddr_o
  );

  modport slave (
    input  start_i, op_i, dividend_i, divisor_i, reg_waddr_i, abort_i,
    output busy_o, ready_o, result_o, reg_we_o, reg_waddr_o
  );
endinterface

// File: rtl/div_seq.sv
// rtl/div_seq.sv - iterative restoring divider for RV32M DIV/DIVU/REM/REMU
//
// Holds the pipeline while a 32-step restoring division runs, then writes the
// quotient or remainder back in a single-cycle strobe.
//   clk  : core clock
//   rst  : synchronous reset, active-low
//   bus  : div_seq_if.slave
//     start_i/op_i/dividend_i/divisor_i/reg_waddr_i : divide request (sampled in IDLE)
//     abort_i     : ex flush, cancels the operation in flight
//     busy_o      : combinational pipeline hold
//     ready_o     : one-cycle result strobe (== reg_we_o)
//     result_o    : quotient or remainder, held until the next strobe
//     reg_waddr_o : rd of the completed divide, held until the next strobe
module div_seq #(
  parameter int DIV_W = 32
) (
  input  logic      clk,
  input  logic      rst,
  div_seq_if.slave  bus
);
  localparam int CNT_W = $clog2(DIV_W) + 1;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIV_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_END  = 2'd2
  } state_e;

  state_e           state_q,      state_d;
  logic [CNT_W-1:0] cnt_q,        cnt_d;
  // dvd_q shifts the dividend out at the top and the quotient bits in at the bottom
  logic [DIV_W-1:0] dvd_q,        dvd_d;
  logic [DIV_W-1:0] dvs_q,        dvs_d;
  logic [DIV_W-1:0] rem_q,        rem_d;
  logic             rem_sel_q,    rem_sel_d;
  logic             q_neg_q,      q_neg_d;
  logic             r_neg_q,      r_neg_d;
  logic [4:0]       waddr_q,      waddr_d;
  logic [DIV_W-1:0] result_q,     result_d;
  logic [4:0]       waddr_out_q,  waddr_out_d;

  logic             accept;
  logic             op_signed;
  logic [DIV_W:0]   rem_shift;
  logic             q_bit;
  logic [DIV_W-1:0] rem_next;
  logic [DIV_W-1:0] q_fin;

  function automatic logic [DIV_W-1:0] magnitude(input logic [DIV_W-1:0] v, input logic sgn);
    return (sgn && v[DIV_W-1]) ? ((~v) + DIV_W'(1)) : v;
  endfunction

  function automatic logic [DIV_W-1:0] cond_neg(input logic [DIV_W-1:0] v, input logic neg);
    return neg ? ((~v) + DIV_W'(1)) : v;
  endfunction

  assign accept    = (state_q == S_IDLE) && bus.start_i && bus.op_i[2] && !bus.abort_i;
  assign op_signed = ~bus.op_i[0];

  // One restoring step. The partial remainder is always below the divisor, so
  // the shifted value needs one extra bit but the difference always fits in DIV_W.
  assign rem_shift = {rem_q, dvd_q[DIV_W-1]};
  assign q_bit     = (rem_shift >= {1'b0, dvs_q});
  assign rem_next  = q_bit ? (rem_shift[DIV_W-1:0] - dvs_q) : rem_shift[DIV_W-1:0];
  assign q_fin     = {dvd_q[DIV_W-2:0], q_bit};

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q       <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      rem_sel_q   <= 1'b0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      waddr_q     <= '0;
      result_q    <= '0;
      waddr_out_q <= '0;
    end else begin
      cnt_q       <= cnt_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      rem_sel_q   <= rem_sel_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      waddr_q     <= waddr_d;
      result_q    <= result_d;
      waddr_out_q <= waddr_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    rem_sel_d   = rem_sel_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    waddr_d     = waddr_q;
    result_d    = result_q;
    waddr_out_d = waddr_out_q;

    unique case (state_q)
      S_IDLE: begin
        if (accept) begin
          rem_sel_d = bus.op_i[1];
          waddr_d   = bus.reg_waddr_i;
          if (bus.divisor_i == '0) begin
            // Divide by zero bypasses CALC: all-ones quotient, dividend as remainder.
            result_d    = bus.op_i[1] ? bus.dividend_i : '1;
            waddr_out_d = bus.reg_waddr_i;
            state_d     = S_END;
          end else begin
            dvd_d   = magnitude(bus.dividend_i, op_signed);
            dvs_d   = magnitude(bus.divisor_i, op_signed);
            rem_d   = '0;
            cnt_d   = '0;
            q_neg_d = op_signed & (bus.dividend_i[DIV_W-1] ^ bus.divisor_i[DIV_W-1]);
            r_neg_d = op_signed & bus.dividend_i[DIV_W-1];
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        if (bus.abort_i) begin
          state_d = S_IDLE;
        end else begin
          dvd_d = q_fin;
          rem_d = rem_next;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_STEP) begin
            // Sign fix-up happens here so result_o is already valid during END.
            // 0x80000000 / -1 falls out naturally: |q| = 0x80000000 negates to itself.
            result_d    = rem_sel_q ? cond_neg(rem_next, r_neg_q) : cond_neg(q_fin, q_neg_q);
            waddr_out_d = waddr_q;
            state_d     = S_END;
          end
        end
      end
      S_END: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are gated by rst so everything reads 0 while reset is asserted.
  assign bus.busy_o      = rst & (accept | (state_q == S_CALC));
  assign bus.ready_o     = rst & (state_q == S_END) & ~bus.abort_i;
  assign bus.reg_we_o    = bus.ready_o;
  assign bus.result_o    = result_q;
  assign bus.reg_waddr_o = waddr_out_q;
endmodule

// File: tb/tb_div_seq.sv
// tb/tb_div_seq.sv - self-checking bench for div_seq against an arithmetic reference model
module tb_div_seq;
  logic clk;
  logic rst;
  int   checks;
  int   errors;

  div_seq_if #(.DIV_W(32)) bus ();

  div_seq #(.DIV_W(32)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: RISC-V M-extension semantics from plain SV arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa;
    logic signed [31:0] sb;
    sa = a;
    sb = b;
    if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
    if (!op[0]) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : 32'h8000_0000;
      return op[1] ? 32'(sa % sb) : 32'(sa / sb);
    end
    return op[1] ? (a % b) : (a / b);
  endfunction

  // Issues one divide in cycle 0 and observes the DUT cycle by cycle.
  // hold: keep start_i high with changing operands until the strobe, and one cycle beyond.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] rd, input bit hold, input int abort_cyc, input int max_cyc,
                        output int lat, output int busy_cnt, output logic [31:0] res,
                        output logic we, output logic [4:0] wa,
                        output logic ready_next, output logic busy_next);
    lat = -1; busy_cnt = 0; res = '0; we = 1'b0; wa = '0; ready_next = 1'b0; busy_next = 1'b0;
    @(posedge clk); #1;
    bus.op_i = op; bus.dividend_i = a; bus.divisor_i = b; bus.reg_waddr_i = rd;
    bus.start_i = 1'b1; bus.abort_i = (abort_cyc == 0);
    for (int k = 0; k <= max_cyc; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        bus.abort_i = (k == abort_cyc);
        if (hold) begin
          bus.op_i = {1'b1, 2'($urandom_range(0, 3))};
          bus.dividend_i = $urandom;
          bus.divisor_i = $urandom;
          bus.reg_waddr_i = 5'($urandom);
        end else begin
          bus.start_i = 1'b0;
        end
      end
      #1;
      if (bus.busy_o === 1'b1) busy_cnt++;
      if (bus.ready_o === 1'b1) begin
        lat = k; res = bus.result_o; we = bus.reg_we_o; wa = bus.reg_waddr_o;
        @(posedge clk); #1;
        bus.abort_i = 1'b0;
        #1;
        ready_next = bus.ready_o;
        busy_next = bus.busy_o;
        break;
      end
    end
    bus.start_i = 1'b0;
    bus.abort_i = 1'b0;
    if (hold) repeat (40) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (bus.busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", bus.busy_o); end
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL reset_ready got %0b want 0", bus.ready_o); end
    checks++; if (bus.reg_we_o !== 1'b0) begin errors++; $display("FAIL reset_we got %0b want 0", bus.reg_we_o); end
    checks++; if (bus.result_o !== 32'd0) begin errors++; $display("FAIL reset_result got %h want 0", bus.result_o); end
    checks++; if (bus.reg_waddr_o !== 5'd0) begin errors++; $display("FAIL reset_waddr got %0d want 0", bus.reg_waddr_o); end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  ops [8] = '{3'b101, 3'b110, 3'b100, 3'b111, 3'b100, 3'b111, 3'b100, 3'b110};
    logic [31:0] as  [8] = '{32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                             32'h0BAD_CAFE, 32'h0000_1234, 32'h8000_0000, 32'h8000_0000};
    logic [31:0] bs  [8] = '{32'd7, 32'd2, 32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] want[8] = '{32'd14, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'd1,
                             32'hFFFF_FFFF, 32'h0000_1234, 32'h8000_0000, 32'd0};
    int lat, bc, wlat;
    logic [31:0] res;
    logic we, rn, bn;
    logic [4:0] wa, rd;
    for (int i = 0; i < 8; i++) begin
      rd = 5'(i + 3);
      wlat = (bs[i] == 32'd0) ? 1 : 33;
      run_op(ops[i], as[i], bs[i], rd, 1'b0, -1, 40, lat, bc, res, we, wa, rn, bn);
      checks++; if (res !== want[i] || res !== model(ops[i], as[i], bs[i]))
        begin errors++; $display("FAIL dir%0d_result got %h want %h", i, res, want[i]); end
      checks++; if (lat !== wlat) begin errors++; $display("FAIL dir%0d_latency got %0d want %0d", i, lat, wlat); end
      checks++; if (bc !== wlat) begin errors++; $display("FAIL dir%0d_busy_cycles got %0d want %0d", i, bc, wlat); end
      checks++; if (we !== 1'b1 || wa !== rd)
        begin errors++; $display("FAIL dir%0d_writeback got we=%0b rd=%0d want we=1 rd=%0d", i, we, wa, rd); end
      checks++; if (rn !== 1'b0) begin errors++; $display("FAIL dir%0d_strobe_width got ready=%0b next cycle want 0", i, rn); end
      checks++; if ($isunknown(res)) begin errors++; $display("FAIL dir%0d_no_x got %h want known", i, res); end
    end
  endtask

  task automatic test_random();
    int lat, bc, wlat;
    logic [31:0] a, b, res, exp;
    logic [2:0] op;
    logic we, rn, bn;
    logic [4:0] wa, rd;
    for (int i = 0; i < 24; i++) begin
      op = {1'b1, 2'($urandom_range(0, 3))};
      case ($urandom_range(0, 5))
        0: a = 32'h8000_0000;
        1: a = $urandom_range(0, 100);
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = $urandom_range(1, 16);
        3: b = 32'd1;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      rd = 5'($urandom);
      exp = model(op, a, b);
      wlat = (b == 32'd0) ? 1 : 33;
      run_op(op, a, b, rd, 1'b0, -1, 40, lat, bc, res, we, wa, rn, bn);
      checks++; if (res !== exp || lat !== wlat || wa !== rd)
        begin errors++; $display("FAIL rnd%0d op=%b a=%h b=%h got res=%h lat=%0d rd=%0d want res=%h lat=%0d rd=%0d",
                                 i, op, a, b, res, lat, wa, exp, wlat, rd); end
    end
  endtask

  task automatic test_abort();
    int lat, bc;
    logic [31:0] res;
    logic we, rn, bn;
    logic [4:0] wa;
    // Abort in CALC: no strobe, busy drops after cycle 10.
    run_op(3'b101, 32'd12345, 32'd11, 5'd9, 1'b0, 10, 45, lat, bc, res, we, wa, rn, bn);
    checks++; if (lat !== -1) begin errors++; $display("FAIL abort_calc_strobe got ready at %0d want none", lat); end
    checks++; if (bc !== 11) begin errors++; $display("FAIL abort_calc_busy_cycles got %0d want 11", bc); end
    run_op(3'b101, 32'd9, 32'd3, 5'd17, 1'b0, -1, 40, lat, bc, res, we, wa, rn, bn);
    checks++; if (res !== 32'd3 || lat !== 33 || wa !== 5'd17)
      begin errors++; $display("FAIL abort_then_divu got res=%h lat=%0d rd=%0d want 3/33/17", res, lat, wa); end
    // Abort in END suppresses the strobe.
    run_op(3'b100, 32'd55, 32'd0, 5'd4, 1'b0, 1, 40, lat, bc, res, we, wa, rn, bn);
    checks++; if (lat !== -1 || bc !== 1)
      begin errors++; $display("FAIL abort_end got ready=%0d busy=%0d want none/1", lat, bc); end
    // Abort with start in IDLE: not accepted.
    run_op(3'b101, 32'd77, 32'd7, 5'd6, 1'b0, 0, 40, lat, bc, res, we, wa, rn, bn);
    checks++; if (lat !== -1 || bc !== 0)
      begin errors++; $display("FAIL abort_idle got ready=%0d busy=%0d want none/0", lat, bc); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    logic [31:0] res, exp;
    logic we, rn, bn;
    logic [4:0] wa;
    exp = model(3'b100, 32'hF000_1234, 32'd77);
    run_op(3'b100, 32'hF000_1234, 32'd77, 5'd21, 1'b1, -1, 40, lat, bc, res, we, wa, rn, bn);
    checks++; if (res !== exp || lat !== 33 || wa !== 5'd21)
      begin errors++; $display("FAIL hold_first_result got res=%h lat=%0d rd=%0d want %h/33/21", res, lat, wa, exp); end
    checks++; if (bc !== 33) begin errors++; $display("FAIL hold_busy_cycles got %0d want 33 (none in END)", bc); end
    checks++; if (bn !== 1'b1) begin errors++; $display("FAIL hold_accept_after_end got busy=%0b want 1", bn); end
  endtask

  task automatic test_reset_midop();
    bit strobe;
    strobe = 1'b0;
    @(posedge clk); #1;
    bus.op_i = 3'b101; bus.dividend_i = 32'd1000; bus.divisor_i = 32'd3; bus.reg_waddr_i = 5'd12;
    bus.start_i = 1'b1;
    for (int k = 1; k <= 21; k++) begin
      @(posedge clk); #1;
      bus.start_i = 1'b0;
      if (k == 19) begin
        #1;
        checks++; if (bus.busy_o !== 1'b1) begin errors++; $display("FAIL rst_mid_busy_before got %0b want 1", bus.busy_o); end
      end
      if (k == 20) rst = 1'b0;
    end
    #1;
    checks++; if (bus.busy_o !== 1'b0 || bus.ready_o !== 1'b0 || bus.reg_we_o !== 1'b0 ||
                  bus.result_o !== 32'd0 || bus.reg_waddr_o !== 5'd0)
      begin errors++; $display("FAIL rst_mid_outputs got busy=%0b ready=%0b we=%0b res=%h rd=%0d want all 0",
                               bus.busy_o, bus.ready_o, bus.reg_we_o, bus.result_o, bus.reg_waddr_o); end
    rst = 1'b1;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.ready_o === 1'b1) strobe = 1'b1;
    end
    checks++; if (strobe) begin errors++; $display("FAIL rst_mid_strobe got ready after reset want none"); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b0;
    bus.start_i = 1'b0;
    bus.op_i = '0;
    bus.dividend_i = '0;
    bus.divisor_i = '0;
    bus.reg_waddr_i = '0;
    bus.abort_i = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_abort();
    test_back_to_back();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
